// File: rtl/vending_pkg.sv
// Shared types and constants for the vending controller.
// State encodings, coin values and a width helper for counters/indices.
package vending_pkg;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_CREDIT   = 2'd1,
        S_DISPENSE = 2'd2,
        S_CHANGE   = 2'd3
    } state_t;

    localparam int COIN5  = 5;
    localparam int COIN10 = 10;

    // Bits needed to hold 0..n-1, never less than one.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vending_if.sv
// Front-end <-> controller bundle: coin/keypad requests in,
// credit, state, dispenser and coin-hopper strobes out.
interface vending_if
    import vending_pkg::*;
#(
    parameter int CREDIT_W = 6,
    parameter int N_PROD   = 4
);
    localparam int SEL_W = cnt_w(N_PROD);

    logic                coin5;
    logic                coin10;
    logic                cancel;
    logic                sel_valid;
    logic [SEL_W-1:0]    sel;

    logic [CREDIT_W-1:0] credit;
    logic [1:0]          state;
    logic                coin_reject;
    logic                sel_error;
    logic                dispense_valid;
    logic [SEL_W-1:0]    dispense_id;
    logic                change10;
    logic                change5;
    logic                busy;

    modport master (
        output coin5, coin10, cancel, sel_valid, sel,
        input  credit, state, coin_reject, sel_error,
        input  dispense_valid, dispense_id,
        input  change10, change5, busy
    );

    modport slave (
        input  coin5, coin10, cancel, sel_valid, sel,
        output credit, state, coin_reject, sel_error,
        output dispense_valid, dispense_id,
        output change10, change5, busy
    );

endinterface

// File: rtl/vending_credit.sv
// Combinational credit datapath: saturating coin add with fit flag,
// price lookup/compare/subtract, and next change-coin decrement.
module vending_credit
    import vending_pkg::*;
#(
    parameter int                  CREDIT_W   = 6,
    parameter int                  N_PROD     = 4,
    parameter logic [N_PROD*8-1:0] PRICE      = {8'd25, 8'd20, 8'd20, 8'd15},
    parameter int                  CREDIT_MAX = 40,
    parameter int                  SEL_W      = cnt_w(N_PROD)
) (
    input  logic [CREDIT_W-1:0] credit,
    input  logic                coin5,
    input  logic                coin10,
    input  logic [SEL_W-1:0]    sel,
    output logic                coin_fit,
    output logic [CREDIT_W-1:0] coin_sum,
    output logic                sel_ok,
    output logic [CREDIT_W-1:0] sel_rem,
    output logic                chg_is10,
    output logic [CREDIT_W-1:0] chg_rem
);

    // Wide enough for credit + 15 and for any 8-bit price.
    localparam int AW = ((CREDIT_W > 8) ? CREDIT_W : 8) + 1;

    logic [AW-1:0] cx;
    logic [AW-1:0] add;
    logic [AW-1:0] sum;
    logic [AW-1:0] price;
    logic [AW-1:0] chg;
    logic          sel_in;

    always_comb begin
        cx  = AW'(credit);
        add = '0;
        if (coin5)
            add = add + AW'(COIN5);
        if (coin10)
            add = add + AW'(COIN10);
        sum = cx + add;
    end

    assign coin_fit = (sum <= AW'(CREDIT_MAX));
    assign coin_sum = CREDIT_W'(sum);

    // Out-of-range index leaves sel_in low and so fails sel_ok.
    always_comb begin
        price  = '0;
        sel_in = 1'b0;
        for (int i = 0; i < N_PROD; i++) begin
            if (32'(sel) == i) begin
                price  = AW'(PRICE[i*8 +: 8]);
                sel_in = 1'b1;
            end
        end
    end

    assign sel_ok  = sel_in && (cx >= price);
    assign sel_rem = CREDIT_W'(cx - price);

    assign chg_is10 = (cx >= AW'(COIN10));
    assign chg      = chg_is10 ? AW'(COIN10) : AW'(COIN5);
    assign chg_rem  = CREDIT_W'(cx - chg);

endmodule

// File: rtl/vending_fsm.sv
// Vending controller: credit FSM, dispense timer and change streamer.
// Ports: clk, rst_n (async, active-low), bus (vending_if.slave).
module vending_fsm
    import vending_pkg::*;
#(
    parameter int                  CREDIT_W        = 6,
    parameter int                  N_PROD          = 4,
    parameter logic [N_PROD*8-1:0] PRICE           = {8'd25, 8'd20, 8'd20, 8'd15},
    parameter int                  CREDIT_MAX      = 40,
    parameter int                  DISPENSE_CYCLES = 2
) (
    input  logic      clk,
    input  logic      rst_n,
    vending_if.slave  bus
);

    localparam int SEL_W = cnt_w(N_PROD);
    localparam int DW    = cnt_w(DISPENSE_CYCLES);
    localparam logic [DW-1:0] D_LOAD = DW'(DISPENSE_CYCLES - 1);

    if (N_PROD < 2) begin : g_bad_nprod
        $error("vending_fsm: N_PROD must be at least 2");
    end
    if (DISPENSE_CYCLES < 1) begin : g_bad_disp
        $error("vending_fsm: DISPENSE_CYCLES must be at least 1");
    end
    if ((CREDIT_MAX % 5) != 0 || CREDIT_MAX >= (1 << CREDIT_W)) begin : g_bad_max
        $error("vending_fsm: CREDIT_MAX illegal");
    end
    for (genvar i = 0; i < N_PROD; i++) begin : g_price_chk
        localparam int P = int'(PRICE[i*8 +: 8]);
        if ((P % 5) != 0 || P == 0 || P > CREDIT_MAX) begin : g_bad_price
            $error("vending_fsm: illegal price entry");
        end
    end

    state_t              state_q;
    logic [CREDIT_W-1:0] credit_q;
    logic                reject_q;
    logic                serr_q;
    logic                dv_q;
    logic [SEL_W-1:0]    did_q;
    logic                c10_q;
    logic                c5_q;
    logic                busy_q;
    logic [DW-1:0]       dcnt_q;

    logic                coin_any;
    logic                coin_fit;
    logic [CREDIT_W-1:0] coin_sum;
    logic                sel_ok;
    logic [CREDIT_W-1:0] sel_rem;
    logic                chg_is10;
    logic [CREDIT_W-1:0] chg_rem;

    assign coin_any = bus.coin5 | bus.coin10;

    vending_credit #(
        .CREDIT_W   (CREDIT_W),
        .N_PROD     (N_PROD),
        .PRICE      (PRICE),
        .CREDIT_MAX (CREDIT_MAX),
        .SEL_W      (SEL_W)
    ) u_credit (
        .credit   (credit_q),
        .coin5    (bus.coin5),
        .coin10   (bus.coin10),
        .sel      (bus.sel),
        .coin_fit (coin_fit),
        .coin_sum (coin_sum),
        .sel_ok   (sel_ok),
        .sel_rem  (sel_rem),
        .chg_is10 (chg_is10),
        .chg_rem  (chg_rem)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            credit_q <= '0;
            reject_q <= 1'b0;
            serr_q   <= 1'b0;
            dv_q     <= 1'b0;
            did_q    <= '0;
            c10_q    <= 1'b0;
            c5_q     <= 1'b0;
            busy_q   <= 1'b0;
            dcnt_q   <= '0;
        end else begin
            reject_q <= 1'b0;
            serr_q   <= 1'b0;
            c10_q    <= 1'b0;
            c5_q     <= 1'b0;
            unique case (state_q)
                S_IDLE, S_CREDIT: begin
                    // Cancel only means something with credit held;
                    // in IDLE it falls through to select/coins.
                    if (bus.cancel && state_q == S_CREDIT) begin
                        state_q  <= S_CHANGE;
                        busy_q   <= 1'b1;
                        reject_q <= coin_any;
                    end else if (bus.sel_valid) begin
                        reject_q <= coin_any;
                        if (sel_ok) begin
                            credit_q <= sel_rem;
                            did_q    <= bus.sel;
                            dv_q     <= 1'b1;
                            dcnt_q   <= D_LOAD;
                            state_q  <= S_DISPENSE;
                            busy_q   <= 1'b1;
                        end else begin
                            serr_q <= 1'b1;
                        end
                    end else if (coin_any) begin
                        if (coin_fit) begin
                            credit_q <= coin_sum;
                            state_q  <= S_CREDIT;
                        end else begin
                            reject_q <= 1'b1;
                        end
                    end
                end
                S_DISPENSE: begin
                    reject_q <= coin_any;
                    if (dcnt_q == '0) begin
                        dv_q <= 1'b0;
                        if (credit_q != '0) begin
                            state_q <= S_CHANGE;
                        end else begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        dcnt_q <= dcnt_q - 1'b1;
                    end
                end
                S_CHANGE: begin
                    reject_q <= coin_any;
                    c10_q    <= chg_is10;
                    c5_q     <= ~chg_is10;
                    credit_q <= chg_rem;
                    // Last coin and return to IDLE share one cycle.
                    if (chg_rem == '0) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign bus.credit         = credit_q;
    assign bus.state          = state_q;
    assign bus.coin_reject    = reject_q;
    assign bus.sel_error      = serr_q;
    assign bus.dispense_valid = dv_q;
    assign bus.dispense_id    = did_q;
    assign bus.change10       = c10_q;
    assign bus.change5        = c5_q;
    assign bus.busy           = busy_q;

endmodule

// File: tb/tb_vending_fsm.sv
// Scoreboard bench for vending_fsm: directed steps push the expected
// output snapshot; a monitor pops and compares after each clock edge.
module tb_vending_fsm;

    typedef struct packed {
        logic [5:0] credit;
        logic [1:0] state;
        logic       rej;
        logic       serr;
        logic       dv;
        logic [1:0] did;
        logic       c10;
        logic       c5;
        logic       busy;
    } out_t;

    typedef struct {
        int   tgt;
        out_t o;
    } sb_t;

    localparam int I = 0;
    localparam int C = 1;
    localparam int D = 2;
    localparam int H = 3;

    localparam logic [5:0] R = 6'b100000;
    localparam logic [5:0] E = 6'b010000;
    localparam logic [5:0] V = 6'b001000;
    localparam logic [5:0] T = 6'b000100;
    localparam logic [5:0] F = 6'b000010;
    localparam logic [5:0] B = 6'b000001;

    localparam logic [3:0] K5  = 4'b1000;
    localparam logic [3:0] K10 = 4'b0100;
    localparam logic [3:0] KC  = 4'b0010;
    localparam logic [3:0] KS  = 4'b0001;
    localparam logic [3:0] K0  = 4'b0000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    sb_t  exp_q[$];

    vending_if #(.CREDIT_W(6), .N_PROD(4)) bus ();

    vending_fsm #(
        .CREDIT_W        (6),
        .N_PROD          (4),
        .PRICE           ({8'd25, 8'd20, 8'd20, 8'd15}),
        .CREDIT_MAX      (40),
        .DISPENSE_CYCLES (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic out_t mk(input int cr, input int st,
                                input int id, input logic [5:0] f);
        out_t o;
        o.credit = 6'(cr);
        o.state  = 2'(st);
        o.did    = 2'(id);
        {o.rej, o.serr, o.dv, o.c10, o.c5, o.busy} = f;
        return o;
    endfunction

    function automatic out_t sample();
        out_t o;
        o.credit = bus.credit;
        o.state  = bus.state;
        o.rej    = bus.coin_reject;
        o.serr   = bus.sel_error;
        o.dv     = bus.dispense_valid;
        o.did    = bus.dispense_id;
        o.c10    = bus.change10;
        o.c5     = bus.change5;
        o.busy   = bus.busy;
        return o;
    endfunction

    function automatic string fmt(input out_t o);
        return $sformatf("cr=%0d st=%0d rej=%b serr=%b dv=%b id=%0d c10=%b c5=%b busy=%b",
                         o.credit, o.state, o.rej, o.serr, o.dv,
                         o.did, o.c10, o.c5, o.busy);
    endfunction

    task automatic check(input string name, input out_t got, input out_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %s, expected %s", name, fmt(got), fmt(exp));
        end
    endtask

    task automatic drive(input logic [3:0] k, input int s);
        {bus.coin5, bus.coin10, bus.cancel, bus.sel_valid} = k;
        bus.sel = 2'(s);
    endtask

    task automatic step(input logic [3:0] k, input int s, input out_t e);
        sb_t ent;
        @(posedge clk);
        #1;
        drive(k, s);
        ent.tgt = cyc + 1;
        ent.o   = e;
        exp_q.push_back(ent);
    endtask

    // Monitor: compare every expectation due at the edge just passed.
    initial begin
        sb_t ent;
        forever begin
            @(posedge clk);
            #3;
            while (exp_q.size() > 0 && exp_q[0].tgt <= cyc) begin
                ent = exp_q.pop_front();
                check($sformatf("cycle%0d", ent.tgt), sample(), ent.o);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        drive(K0, 0);
        #12;
        check("reset_state", sample(), '0);
        #10;
        rst_n = 1'b1;

        // Async reset mid-stream
        step(K10, 0, mk(10, C, 0, 0));
        @(posedge clk);
        #4;
        drive(K0, 0);
        rst_n = 1'b0;
        #1;
        check("async_reset", sample(), '0);
        #2;
        rst_n = 1'b1;

        // Select in IDLE errors; cancel in IDLE is ignored
        step(KS, 1, mk(0, I, 0, E));
        step(KC, 0, mk(0, I, 0, 0));

        // Double coins, saturation reject, buy product 3
        step(K5 | K10, 0, mk(15, C, 0, 0));
        step(K5 | K10, 0, mk(30, C, 0, 0));
        step(K10, 0, mk(40, C, 0, 0));
        step(K5, 0, mk(40, C, 0, R));
        step(KS, 3, mk(15, D, 3, V | B));
        step(K0, 0, mk(15, D, 3, V | B));
        step(K0, 0, mk(15, H, 3, B));
        step(K0, 0, mk(5, H, 3, T | B));
        step(K0, 0, mk(0, I, 3, F));
        step(K0, 0, mk(0, I, 3, 0));

        // Insufficient credit, then cancel
        step(K10, 0, mk(10, C, 3, 0));
        step(KS, 3, mk(10, C, 3, E));
        step(KC, 0, mk(10, H, 3, B));
        step(K0, 0, mk(0, I, 3, T));
        step(K0, 0, mk(0, I, 3, 0));

        // Credit 35 refund, coin during CHANGE rejected
        step(K10, 0, mk(10, C, 3, 0));
        step(K10, 0, mk(20, C, 3, 0));
        step(K10, 0, mk(30, C, 3, 0));
        step(K5, 0, mk(35, C, 3, 0));
        step(KC, 0, mk(35, H, 3, B));
        step(K0, 0, mk(25, H, 3, T | B));
        step(K5, 0, mk(15, H, 3, R | T | B));
        step(K0, 0, mk(5, H, 3, T | B));
        step(K0, 0, mk(0, I, 3, F));
        step(K0, 0, mk(0, I, 3, 0));

        // Cancel beats select and coin in the same cycle
        step(K10, 0, mk(10, C, 3, 0));
        step(K10, 0, mk(20, C, 3, 0));
        step(K5 | KC | KS, 0, mk(20, H, 3, R | B));
        step(K0, 0, mk(10, H, 3, T | B));
        step(K0, 0, mk(0, I, 3, T));
        step(K0, 0, mk(0, I, 3, 0));

        // Buy product 0 with change; coin during DISPENSE rejected
        step(K10, 0, mk(10, C, 3, 0));
        step(K10, 0, mk(20, C, 3, 0));
        step(KS, 0, mk(5, D, 0, V | B));
        step(K5, 0, mk(5, D, 0, R | V | B));
        step(K0, 0, mk(5, H, 0, B));
        step(K0, 0, mk(0, I, 0, F));
        step(K0, 0, mk(0, I, 0, 0));

        // Exact price: no change phase
        step(K5 | K10, 0, mk(15, C, 0, 0));
        step(KS, 0, mk(0, D, 0, V | B));
        step(K0, 0, mk(0, D, 0, V | B));
        step(K0, 0, mk(0, I, 0, 0));
        step(K0, 0, mk(0, I, 0, 0));

        repeat (3) @(posedge clk);
        #5;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d pending, expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vending_fsm.md
# vending_fsm

Parametrised vending controller: the next generation of the coffee FSM. Accepts 5- and 10-unit coins into a saturating credit register and serves one of N_PROD products with per-product prices. Returns change or a cancelled credit as a stream of coin strobes. Sits between the coin/keypad front-end and the dispenser/coin-hopper drivers.

## Interface
- CREDIT_W, 6: credit register width in money units.
- N_PROD, 4: number of selectable products (≥2).
- PRICE, {8'd25,8'd20,8'd20,8'd15}: packed N_PROD×8 price vector, product 0 in LSBs; every price a multiple of 5, nonzero, ≤ CREDIT_MAX.
- CREDIT_MAX, 40: saturation limit, multiple of 5, < 2^CREDIT_W.
- DISPENSE_CYCLES, 2: cycles dispense_valid is held (≥1).
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- coin5, coin10  in  1 each  one-cycle coin-accepted pulses.
- cancel  in  1  refund request pulse.
- sel_valid  in  1  selection strobe.
- sel  in  $clog2(N_PROD)  product index.
- credit  out  CREDIT_W  current credit.
- state  out  2  current state encoding.
- coin_reject  out  1  coin(s) refused this cycle.
- sel_error  out  1  insufficient credit or index ≥ N_PROD.
- dispense_valid  out  1  dispenser drive.
- dispense_id  out  $clog2(N_PROD)  product being dispensed.
- change10, change5  out  1 each  one-coin return strobes.
- busy  out  1  high in DISPENSE and CHANGE.

## Operation
- States: IDLE=0 (credit==0), CREDIT=1, DISPENSE=2, CHANGE=3.
- Priority within IDLE/CREDIT, per cycle: cancel > sel_valid > coins.
- Coins: add = 5·coin5 + 10·coin10 (both → 15). If credit+add > CREDIT_MAX, whole add is refused, coin_reject pulses, credit unchanged. Accepted coin in IDLE → CREDIT.
- Coins arriving in DISPENSE/CHANGE, or in the same cycle as an honoured cancel/sel_valid: refused, coin_reject pulses.
- sel_valid: if sel < N_PROD and credit ≥ PRICE[sel], subtract price, latch dispense_id, go to DISPENSE. Otherwise pulse sel_error and hold state/credit (also in IDLE).
- cancel in CREDIT → CHANGE with credit intact; cancel in IDLE ignored; cancel/sel_valid ignored while busy.
- DISPENSE: dispense_valid high for exactly DISPENSE_CYCLES cycles, then → CHANGE if credit>0 else → IDLE.
- CHANGE: one strobe per cycle, change10 while credit ≥ 10, else change5; credit decremented on the same edge; → IDLE on the cycle credit reaches 0.

## Timing
- All outputs registered; the reset value of every output is 0 (state=IDLE, credit=0, all strobes low).
- Coin/select/cancel response visible one cycle after the input edge (credit, state, coin_reject, sel_error all update together).
- dispense_valid rises the cycle after an accepted sel_valid.
- Change strobes are contiguous: n coins → n consecutive cycles, busy high throughout, low the cycle state returns to IDLE.
- Reset asserted mid-DISPENSE or mid-CHANGE: immediate return to IDLE, credit cleared, strobes dropped (remaining credit is lost; this is by design).

## Structure
- Package vending_pkg: state encodings, COIN5/COIN10 values, dispense counter width helper.
- One sub-module, vending_credit: saturating add with reject flag, price compare/subtract, change-coin decrement; FSM and dispense counter stay in vending_fsm.
- Parameter legality (price multiples, CREDIT_MAX < 2^CREDIT_W) checked by elaboration-time assertions.

## Test plan
- Reset mid-stream: coin10, then rst_n low → credit 0, state IDLE, all outputs 0 asynchronously.
- coin10, coin10, sel=0 → credit 20→5, dispense_valid 2 cycles with id 0, one change5, then IDLE.
- coin5+coin10 same cycle ×2, then coin10 → credit 15, 30, 40; next coin5 → coin_reject, credit stays 40.
- credit 10, sel=3 (price 25) → sel_error one cycle, state CREDIT, credit 10; then cancel → change10, IDLE.
- credit 35, cancel → change10, change10, change10, change5 on 4 consecutive cycles; coin5 during CHANGE → coin_reject.
- credit 20, sel_valid + cancel + coin5 same cycle → cancel wins, coin_reject, change10 ×2.
